// File: rtl/weight_tile_sequencer.sv
// weight_tile_sequencer
//   Frames the weight DMA AXI-Stream into tiles of ROWS*BEATS_PER_ROW beats
//   and forwards every accepted beat to the weight buffer one cycle later.
//   It also manages the ping-pong banks: while the write bank holds a finished
//   tile and the read bank is still occupied, the stream is back-pressured.
//   On a core load request it drives the ROWS-cycle weight-load enable.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   s_axis_*          weight beats from DMA (tready decodes from write state)
//   m_axis_*          registered beats to the weight buffer (always ready)
//   o_bank_swap       one-cycle pulse: buffer flips write/read banks
//   i_load_req        level request from the core to load the ready tile
//   o_weight_load_en  high for ROWS consecutive cycles per load
//   o_load_done       one-cycle pulse after the final load cycle
//   o_tile_ready      a full tile sits in the read bank, not yet loaded
//   o_err_tlast       sticky tlast/count disagreement flag
module weight_tile_sequencer #(
    parameter int ROWS          = 12,
    parameter int BEATS_PER_ROW = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        o_bank_swap,
    input  logic        i_load_req,
    output logic        o_weight_load_en,
    output logic        o_load_done,
    output logic        o_tile_ready,
    output logic        o_err_tlast
);

    localparam int TILE_BEATS = ROWS * BEATS_PER_ROW;
    localparam int CNT_W      = $clog2(TILE_BEATS);
    localparam int LOAD_W     = 4;

    localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(TILE_BEATS - 1);
    localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(ROWS - 1);

    typedef enum logic [1:0] {
        W_FILL  = 2'd0,
        W_DRAIN = 2'd1,
        W_FULL  = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        R_EMPTY   = 2'd0,
        R_READY   = 2'd1,
        R_LOADING = 2'd2
    } rstate_t;

    wstate_t           wstate_r;
    rstate_t           rstate_r;
    logic [CNT_W-1:0]  beat_cnt_r;
    logic              drain_cnt_r;
    logic [LOAD_W-1:0] load_cnt_r;

    logic accept_s;
    logic last_beat_s;
    logic swap_s;

    // Handshake, tile-boundary and swap-condition decode.
    always_comb begin
        s_axis_tready = (wstate_r == W_FILL);
        o_tile_ready  = (rstate_r == R_READY);
        accept_s      = s_axis_tvalid & s_axis_tready;
        last_beat_s   = (beat_cnt_r == BEAT_LAST);
        // Swap only once the finished tile has fully left the forward register.
        swap_s        = (wstate_r == W_FULL) && (rstate_r == R_EMPTY) && !m_axis_tvalid;
    end

    // Forward path: one-cycle registered copy of accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tdata  <= 64'd0;
            m_axis_tvalid <= 1'b0;
        end else begin
            m_axis_tvalid <= accept_s;
            if (accept_s) begin
                m_axis_tdata <= s_axis_tdata;
            end
        end
    end

    // Write FSM, read FSM, bank swap, load sequencing and framing check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_r         <= W_FILL;
            rstate_r         <= R_EMPTY;
            beat_cnt_r       <= {CNT_W{1'b0}};
            drain_cnt_r      <= 1'b0;
            load_cnt_r       <= {LOAD_W{1'b0}};
            o_bank_swap      <= 1'b0;
            o_weight_load_en <= 1'b0;
            o_load_done      <= 1'b0;
            o_err_tlast      <= 1'b0;
        end else begin
            o_bank_swap <= swap_s;
            o_load_done <= 1'b0;

            case (wstate_r)
                W_FILL: begin
                    if (accept_s) begin
                        // Framing is by count; tlast only feeds the error flag.
                        if (s_axis_tlast != last_beat_s) begin
                            o_err_tlast <= 1'b1;
                        end
                        if (last_beat_s) begin
                            beat_cnt_r  <= {CNT_W{1'b0}};
                            drain_cnt_r <= 1'b0;
                            wstate_r    <= W_DRAIN;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                W_DRAIN: begin
                    // Two cycles for the buffer gearbox to commit the last row.
                    if (drain_cnt_r) begin
                        wstate_r <= W_FULL;
                    end else begin
                        drain_cnt_r <= 1'b1;
                    end
                end
                W_FULL: begin
                    if (swap_s) begin
                        wstate_r <= W_FILL;
                    end
                end
                default: begin
                    wstate_r <= W_FILL;
                end
            endcase

            case (rstate_r)
                R_EMPTY: begin
                    if (swap_s) begin
                        rstate_r <= R_READY;
                    end
                end
                R_READY: begin
                    if (i_load_req) begin
                        rstate_r         <= R_LOADING;
                        load_cnt_r       <= {LOAD_W{1'b0}};
                        o_weight_load_en <= 1'b1;
                    end
                end
                R_LOADING: begin
                    if (load_cnt_r == LOAD_LAST) begin
                        o_weight_load_en <= 1'b0;
                        o_load_done      <= 1'b1;
                        rstate_r         <= R_EMPTY;
                    end else begin
                        load_cnt_r <= load_cnt_r + {{(LOAD_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    rstate_r         <= R_EMPTY;
                    o_weight_load_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_tile_sequencer.sv
// Directed bench for weight_tile_sequencer: reset, single tile, load,
// back-pressure with two tiles, framing error and reset during a load.
module tb_weight_tile_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        o_bank_swap;
    logic        i_load_req;
    logic        o_weight_load_en;
    logic        o_load_done;
    logic        o_tile_ready;
    logic        o_err_tlast;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    weight_tile_sequencer #(.ROWS(12), .BEATS_PER_ROW(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tlast     (s_axis_tlast),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .o_bank_swap      (o_bank_swap),
        .i_load_req       (i_load_req),
        .o_weight_load_en (o_weight_load_en),
        .o_load_done      (o_load_done),
        .o_tile_ready     (o_tile_ready),
        .o_err_tlast      (o_err_tlast)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sends 24 back-to-back beats base+k; returns in the cycle after the last beat.
    task automatic send_tile(input int tlast_beat, input logic [63:0] base);
        for (int k = 0; k < 24; k++) begin
            s_axis_tdata  = base + 64'(k);
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (k == tlast_beat);
            checks++;
            if (s_axis_tready !== 1'b1) begin
                failures++;
                $display("FAIL send_tready beat=%0d got=%b exp=1", k, s_axis_tready);
            end
            tick;
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== base + 64'(k)) begin
                failures++;
                $display("FAIL fwd_beat beat=%0d got_v=%b got_d=%h exp_v=1 exp_d=%h",
                         k, m_axis_tvalid, m_axis_tdata, base + 64'(k));
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic test_reset;
        logic [6:0] got;
        rst_n = 1'b0;
        s_axis_tdata = 64'hDEAD_BEEF_0000_0001;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        i_load_req = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            s_axis_tvalid = i[0];
            tick;
            got = {s_axis_tready, m_axis_tvalid, o_bank_swap, o_weight_load_en,
                   o_load_done, o_tile_ready, o_err_tlast};
            checks++;
            if (got !== 7'b1000000 || m_axis_tdata !== 64'd0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b data=%h exp=1000000 data=0", i, got, m_axis_tdata);
            end
        end
        s_axis_tvalid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            got = {s_axis_tready, m_axis_tvalid, o_bank_swap, o_weight_load_en,
                   o_load_done, o_tile_ready, o_err_tlast};
            checks++;
            if (got !== 7'b1000000 || m_axis_tdata !== 64'd0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%b data=%h exp=1000000 data=0", i, got, m_axis_tdata);
            end
        end
    endtask

    task automatic test_single_tile;
        send_tile(23, 64'd0);
        // Cycles t+1..t+3: drain and full, stream stalled, no swap yet.
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (s_axis_tready !== 1'b0 || o_bank_swap !== 1'b0 ||
                (i > 0 && m_axis_tvalid !== 1'b0)) begin
                failures++;
                $display("FAIL tile_stall cyc=%0d got_rdy=%b swap=%b mv=%b exp_rdy=0 swap=0",
                         i, s_axis_tready, o_bank_swap, m_axis_tvalid);
            end
            tick;
        end
        checks++;
        if (o_bank_swap !== 1'b1 || s_axis_tready !== 1'b1 || o_tile_ready !== 1'b1) begin
            failures++;
            $display("FAIL tile_swap got_swap=%b rdy=%b tile=%b exp=1 1 1",
                     o_bank_swap, s_axis_tready, o_tile_ready);
        end
        tick;
        checks++;
        if (o_bank_swap !== 1'b0 || o_tile_ready !== 1'b1 || o_err_tlast !== 1'b0) begin
            failures++;
            $display("FAIL tile_after got_swap=%b tile=%b err=%b exp=0 1 0",
                     o_bank_swap, o_tile_ready, o_err_tlast);
        end
    endtask

    task automatic test_load;
        i_load_req = 1'b1;
        tick;
        i_load_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (o_weight_load_en !== 1'b1 || o_load_done !== 1'b0 || o_tile_ready !== 1'b0) begin
                failures++;
                $display("FAIL load_en cyc=%0d got_en=%b done=%b tile=%b exp=1 0 0",
                         i, o_weight_load_en, o_load_done, o_tile_ready);
            end
            tick;
        end
        checks++;
        if (o_weight_load_en !== 1'b0 || o_load_done !== 1'b1) begin
            failures++;
            $display("FAIL load_done got_en=%b done=%b exp=0 1", o_weight_load_en, o_load_done);
        end
        tick;
        checks++;
        if (o_weight_load_en !== 1'b0 || o_load_done !== 1'b0 || o_tile_ready !== 1'b0) begin
            failures++;
            $display("FAIL load_after got_en=%b done=%b tile=%b exp=0 0 0",
                     o_weight_load_en, o_load_done, o_tile_ready);
        end
    endtask

    task automatic test_back_to_back;
        int   accepted = 0;
        int   stalls   = 0;
        int   swaps    = 0;
        int   cyc      = 0;
        logic was_acc;
        s_axis_tvalid = 1'b1;
        while (accepted < 48 && cyc < 200) begin
            s_axis_tdata = 64'h1000 + 64'(accepted);
            s_axis_tlast = ((accepted % 24) == 23);
            was_acc = s_axis_tready;
            if (o_bank_swap === 1'b1) swaps++;
            if (s_axis_tready !== 1'b1) stalls++;
            tick;
            cyc++;
            if (was_acc) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'h1000 + 64'(accepted)) begin
                    failures++;
                    $display("FAIL b2b_fwd beat=%0d got_v=%b d=%h exp_v=1 d=%h",
                             accepted, m_axis_tvalid, m_axis_tdata, 64'h1000 + 64'(accepted));
                end
                accepted++;
            end
        end
        checks++;
        if (accepted != 48 || stalls != 3 || swaps != 1) begin
            failures++;
            $display("FAIL b2b_stream got_acc=%0d stalls=%0d swaps=%0d exp=48 3 1", accepted, stalls, swaps);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (s_axis_tready !== 1'b0 || o_bank_swap !== 1'b0 || o_tile_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_hold cyc=%0d got_rdy=%b swap=%b tile=%b exp=0 0 1",
                         i, s_axis_tready, o_bank_swap, o_tile_ready);
            end
            tick;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        i_load_req = 1'b1;
        tick;
        i_load_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (o_weight_load_en !== 1'b1 || s_axis_tready !== 1'b0 || o_bank_swap !== 1'b0) begin
                failures++;
                $display("FAIL b2b_load cyc=%0d got_en=%b rdy=%b swap=%b exp=1 0 0",
                         i, o_weight_load_en, s_axis_tready, o_bank_swap);
            end
            tick;
        end
        checks++;
        if (o_load_done !== 1'b1 || o_bank_swap !== 1'b0 || s_axis_tready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done got_done=%b swap=%b rdy=%b exp=1 0 0",
                     o_load_done, o_bank_swap, s_axis_tready);
        end
        tick;
        checks++;
        if (o_bank_swap !== 1'b1 || s_axis_tready !== 1'b1 || o_tile_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_swap got_swap=%b rdy=%b tile=%b exp=1 1 1",
                     o_bank_swap, s_axis_tready, o_tile_ready);
        end
        // Consume the second tile so the read bank is empty again.
        i_load_req = 1'b1;
        tick;
        i_load_req = 1'b0;
        repeat (13) tick;
        checks++;
        if (o_tile_ready !== 1'b0 || o_weight_load_en !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain got_tile=%b en=%b exp=0 0", o_tile_ready, o_weight_load_en);
        end
    endtask

    task automatic test_framing;
        for (int k = 0; k < 24; k++) begin
            s_axis_tdata  = 64'h2000 + 64'(k);
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (k == 10);
            tick;
            checks++;
            if (o_err_tlast !== (k >= 10)) begin
                failures++;
                $display("FAIL frame_err beat=%0d got=%b exp=%b", k, o_err_tlast, (k >= 10));
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        checks++;
        if (s_axis_tready !== 1'b0) begin
            failures++;
            $display("FAIL frame_complete got_rdy=%b exp=0", s_axis_tready);
        end
        repeat (3) tick;
        checks++;
        if (o_bank_swap !== 1'b1 || o_err_tlast !== 1'b1) begin
            failures++;
            $display("FAIL frame_swap got_swap=%b err=%b exp=1 1", o_bank_swap, o_err_tlast);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_err_tlast !== 1'b0 || s_axis_tready !== 1'b1 || o_tile_ready !== 1'b0) begin
            failures++;
            $display("FAIL frame_reset got_err=%b rdy=%b tile=%b exp=0 1 0",
                     o_err_tlast, s_axis_tready, o_tile_ready);
        end
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset_mid_load;
        send_tile(23, 64'hA5A5_0000_0000_0000);
        repeat (3) tick;
        checks++;
        if (o_bank_swap !== 1'b1) begin
            failures++;
            $display("FAIL midload_swap got=%b exp=1", o_bank_swap);
        end
        i_load_req = 1'b1;
        tick;
        i_load_req = 1'b0;
        repeat (4) tick;
        checks++;
        if (o_weight_load_en !== 1'b1) begin
            failures++;
            $display("FAIL midload_en5 got=%b exp=1", o_weight_load_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_weight_load_en !== 1'b0 || o_tile_ready !== 1'b0) begin
            failures++;
            $display("FAIL midload_drop got_en=%b tile=%b exp=0 0", o_weight_load_en, o_tile_ready);
        end
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (o_weight_load_en !== 1'b0 || o_load_done !== 1'b0 || o_bank_swap !== 1'b0) begin
                failures++;
                $display("FAIL midload_quiet cyc=%0d got_en=%b done=%b swap=%b exp=0 0 0",
                         i, o_weight_load_en, o_load_done, o_bank_swap);
            end
            tick;
        end
        send_tile(23, 64'h0000_0077_0000_0000);
        repeat (3) tick;
        checks++;
        if (o_bank_swap !== 1'b1 || o_tile_ready !== 1'b1 || o_err_tlast !== 1'b0) begin
            failures++;
            $display("FAIL midload_fresh got_swap=%b tile=%b err=%b exp=1 1 0",
                     o_bank_swap, o_tile_ready, o_err_tlast);
        end
    endtask

    initial begin
        test_reset;
        test_single_tile;
        test_load;
        test_back_to_back;
        test_framing;
        test_reset_mid_load;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/weight_tile_sequencer.md
# weight_tile_sequencer

Framing and ping-pong sequencer between the weight DMA AXI-Stream and the weight buffer. It forwards 64-bit weight beats to the buffer and counts them into tiles of ROWS × BEATS_PER_ROW beats. It applies back-pressure while the write bank is full and the read bank is still occupied, and issues the bank-swap pulse. On core request it drives the 12-cycle weight-load enable toward the systolic array.

## Interface
- ROWS, 12, array rows per weight tile (one 128-bit row each)
- BEATS_PER_ROW, 2, 64-bit beats per 128-bit row
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  64  weight beat from DMA
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accepted when high with tvalid
- s_axis_tlast  in  1  marks last beat of a tile; checked, not used for framing
- m_axis_tdata  out  64  registered beat to weight buffer
- m_axis_tvalid  out  1  registered valid to weight buffer; buffer is always ready
- o_bank_swap  out  1  one-cycle pulse to buffer bank swap
- i_load_req  in  1  level; core requests a tile load into the array
- o_weight_load_en  out  1  high for exactly ROWS consecutive cycles per load
- o_load_done  out  1  one-cycle pulse after last load cycle
- o_tile_ready  out  1  a complete tile sits in the read bank, not yet loaded
- o_err_tlast  out  1  sticky framing error

## Operation
- TILE_BEATS = ROWS*BEATS_PER_ROW (24). The beat counter is ceil(log2(TILE_BEATS)) bits wide and wraps to 0 after TILE_BEATS-1.
- Write FSM wstate:
  - FILL: s_axis_tready=1 (combinational from state). Each accepted beat increments the counter. The accepted beat with counter==TILE_BEATS-1 clears the counter and moves to DRAIN.
  - DRAIN: 2 cycles, tready=0, lets the buffer gearbox commit the final row.
  - DRAIN then moves to FULL: tready=0.
- Read FSM rstate:
  - EMPTY goes to READY by a swap.
  - READY: o_tile_ready=1. At an edge with i_load_req=1, moves to LOADING.
  - LOADING: o_weight_load_en=1 for ROWS cycles. The load counter (4 bits) counts 0..ROWS-1. At the final edge, load_en drops, o_load_done pulses, and rstate goes to EMPTY.
- Swap: at an edge with wstate==FULL and rstate==EMPTY:
  - o_bank_swap<=1 for one cycle.
  - wstate<=FILL, rstate<=READY.
  - Swap is never issued while LOADING or READY, and never while m_axis_tvalid is pending.
- Simultaneous events:
  - At a swap edge, i_load_req is ignored because rstate is still EMPTY.
  - The load starts at the earliest edge ending the swap-pulse cycle. The buffer flips its bank at that same edge, so the first load_en cycle reads the new bank.
- tlast check: o_err_tlast<=1 on an accepted beat in either case:
  - tlast=1 with counter≠TILE_BEATS-1;
  - tlast=0 with counter==TILE_BEATS-1.
  - Framing continues by count. The flag is cleared only by reset.
- Reset mid-operation: every counter and FSM returns to reset state and any partial tile is discarded. The buffer shares rst_n, so its bank select is realigned.

## Timing
- Reset values:
  - s_axis_tready=1 (wstate=FILL)
  - m_axis_tdata=0, m_axis_tvalid=0
  - o_bank_swap=0, o_weight_load_en=0, o_load_done=0
  - o_tile_ready=0, o_err_tlast=0
- Forward path:
  - A beat accepted at edge t appears on m_axis with tvalid=1 during cycle t+1 (1-cycle latency).
  - m_axis_tvalid=0 in cycles without an accepted beat.
- Tile completion:
  - Last beat accepted at edge t gives DRAIN in cycles t+1 and t+2, then FULL from t+3.
  - With the read bank EMPTY, o_bank_swap is high in cycle t+4 and tready returns to 1 in that same cycle t+4.
- Load:
  - i_load_req seen at edge u in READY gives load_en high for cycles u+1..u+ROWS.
  - o_load_done is high in cycle u+ROWS+1, and o_tile_ready drops in cycle u+1.
  - A waiting FULL tile swaps at the edge ending cycle u+ROWS+1, so o_bank_swap is high in cycle u+ROWS+2.
- Outputs are registered, except s_axis_tready and o_tile_ready, which decode directly from state.

## Test plan
- Reset:
  - Hold rst_n low with tvalid toggling.
  - Required: tready=1, all other outputs 0.
  - After release with no stimulus, nothing changes.
- Single tile:
  - Send 24 beats back-to-back, beat k = k, tlast on beat 23.
  - Required: m_axis mirrors with 1-cycle lag; tready low for 3 cycles; a 1-cycle o_bank_swap; o_tile_ready=1 afterwards; o_err_tlast=0.
- Load:
  - Assert i_load_req after the tile is ready.
  - Required: exactly 12 load_en cycles, then one o_load_done cycle; o_tile_ready=0.
- Back-pressure:
  - Stream 48 beats continuously with no load request.
  - Required: the second tile fills, then tready stays 0 indefinitely.
  - Assert i_load_req. Required: swap 2 cycles after the 12th load_en cycle, then tready=1.
- Framing error:
  - tlast on beat 10. Required: o_err_tlast=1 from the next cycle; the tile still completes at beat 23.
  - Assert rst_n low. Required: the flag clears.
- Reset mid-load:
  - Pulse rst_n low during load cycle 5.
  - Required: load_en drops immediately with no o_load_done; after release, a fresh 24-beat tile swaps normally.
